// File: rtl/stage_c_read_pkg.sv
// Shared opcode constants: one-hot bit positions of the pipeline operation word.
package stage_c_read_pkg;

  localparam int unsigned OP_INC     = 0;
  localparam int unsigned OP_DEC     = 1;
  localparam int unsigned OP_LEFT    = 2;
  localparam int unsigned OP_RIGHT   = 3;
  localparam int unsigned OP_OUT     = 4;
  localparam int unsigned OP_IN      = 5;
  localparam int unsigned OP_JZ      = 6;
  localparam int unsigned OP_JNZ     = 7;
  localparam int unsigned OPCODE_MSB = 7;

endpackage

// File: rtl/stage_c_read.sv
// Operand-fetch stage: reads the data cell at dp (with write-back forwarding) or
// consumes an external input byte, and hands the operation plus operand downstream.
module stage_c_read
  import stage_c_read_pkg::*;
#(
  parameter int unsigned A_WIDTH = 12,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [A_WIDTH-1:0]    dp,
  output logic                  dce,
  output logic [A_WIDTH-1:0]    da,
  input  logic [D_WIDTH-1:0]    dd,
  input  logic                  wdce,
  input  logic [A_WIDTH-1:0]    wda,
  input  logic [D_WIDTH-1:0]    wdq,
  input  logic [7:0]            cd,
  input  logic                  crda,
  output logic                  cack,
  input  logic [OPCODE_MSB:0]   operation_in,
  output logic                  ack,
  output logic [OPCODE_MSB:0]   operation,
  input  logic                  ack_in,
  output logic [D_WIDTH-1:0]    a_out
);

  function automatic logic is_read_op(input logic [OPCODE_MSB:0] op);
    return op[OP_INC] | op[OP_DEC] | op[OP_OUT];
  endfunction

  function automatic logic is_in_op(input logic [OPCODE_MSB:0] op);
    return op[OP_IN];
  endfunction

  logic [OPCODE_MSB:0] operation_q, operation_d;
  logic [D_WIDTH-1:0]  a_hold_q, a_hold_d;
  logic [D_WIDTH-1:0]  fwd_data_q, fwd_data_d;
  logic                fresh_q, fresh_d;
  logic                fwd_q, fwd_d;
  logic                in_wait, accept, rd_op, in_op;
  logic [D_WIDTH-1:0]  fresh_val;

  assign rd_op   = is_read_op(operation_in);
  assign in_op   = is_in_op(operation_in);
  assign in_wait = in_op & ~crda;
  assign accept  = ack_in & ~in_wait;

  assign ack  = reset & accept;
  assign dce  = reset & ack_in & rd_op;
  assign cack = reset & accept & in_op;
  assign da   = dp;

  assign fresh_val = fwd_q ? fwd_data_q : dd;
  assign a_out     = fresh_q ? fresh_val : a_hold_q;
  assign operation = operation_q;

  always_comb begin
    operation_d = operation_q;
    a_hold_d    = a_hold_q;
    fwd_data_d  = fwd_data_q;
    fresh_d     = 1'b0;
    fwd_d       = 1'b0;
    // Latch the freshly read byte so it survives a downstream stall.
    if (fresh_q) a_hold_d = fresh_val;
    if (ack_in) begin
      if (in_wait) begin
        operation_d = '0;
        a_hold_d    = '0;
      end else begin
        operation_d = operation_in;
        if (rd_op) begin
          fresh_d    = 1'b1;
          fwd_d      = wdce && (wda == dp);
          fwd_data_d = wdq;
        end else if (in_op) begin
          a_hold_d = D_WIDTH'(cd);
        end else begin
          a_hold_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      operation_q <= '0;
      a_hold_q    <= '0;
      fwd_data_q  <= '0;
      fresh_q     <= 1'b0;
      fwd_q       <= 1'b0;
    end else begin
      operation_q <= operation_d;
      a_hold_q    <= a_hold_d;
      fwd_data_q  <= fwd_data_d;
      fresh_q     <= fresh_d;
      fwd_q       <= fwd_d;
    end
  end

endmodule

// File: doc/stage_c_read.md
STAGE_C_READ -- requirements
Module: stage_c_read

Interface
REQ-001 A_WIDTH, default 12, data-RAM address width.
REQ-002 D_WIDTH, default 8, data cell width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 dp  in  A_WIDTH  current data pointer.
REQ-006 dce  out  1  data-RAM read enable.
REQ-007 da  out  A_WIDTH  data-RAM read address.
REQ-008 dd  in  D_WIDTH  data-RAM read data, valid the cycle after dce.
REQ-009 wdce  in  1  downstream write-back strobe.
REQ-010 wda  in  A_WIDTH  downstream write address.
REQ-011 wdq  in  D_WIDTH  downstream write data.
REQ-012 cd  in  8  external input byte.
REQ-013 crda  in  1  external byte available.
REQ-014 cack  out  1  one-cycle consume strobe for cd.
REQ-015 operation_in  in  OPCODE_MSB+1  one-hot op from upstream.
REQ-016 ack  out  1  upstream may advance.
REQ-017 operation  out  OPCODE_MSB+1  registered op to downstream.
REQ-018 ack_in  in  1  downstream advances.
REQ-019 a_out  out  D_WIDTH  operand for downstream.

Function
REQ-020 Read ops: OP_INC, OP_DEC, OP_OUT; input op: OP_IN; all others carry no operand.
REQ-021 dce = reset high and ack_in and read op on operation_in; da = dp combinationally.
REQ-022 Accept = ack_in and not in_wait; on accept operation <= operation_in.
REQ-023 in_wait = OP_IN on operation_in and crda low.
REQ-024 ack_in high and in_wait: operation <= 0 (bubble); ack low.
REQ-025 ack_in low: operation, operand and flags hold; no dce, no cack.
REQ-026 ack = ack_in and not in_wait.
REQ-027 OP_IN accept (crda high): capture cd, cack high for that cycle only.
REQ-028 Forward hit = wdce and wda == dp in a read-op accept cycle; capture wdq, select it over dd.
REQ-029 Cycle after read-op accept ("fresh"): a_out = forwarded byte if hit else dd; a_hold <= that value.
REQ-030 Not fresh: a_out = a_hold; fresh clears after one cycle even if ack_in low.
REQ-031 OP_IN: a_out = captured cd from load cycle onward; non-operand ops: a_hold <= 0.
REQ-032 Back-to-back read ops with ack_in high: one op per cycle, no bubbles.
REQ-033 Simultaneous crda rise and ack_in fall: no accept, no cack.

Reset
REQ-034 reset low: operation 0, a_hold 0, fresh 0, forward flag 0, cack 0, dce 0, ack 0.
REQ-035 reset mid-stall on OP_IN: wait abandoned, no cack; resumes in accept state after release.

Structure
REQ-036 OP_* bit indices and OPCODE_MSB from the shared constants file; no local opcode values.
REQ-037 Read-op/input-op classification as local functions; no sub-module.
REQ-038 Single flat module, no memories inside; RAM external.

Verification
REQ-039 Reset low 2 cycles, release -> operation 0, a_out 0, dce 0, cack 0.
REQ-040 OP_INC, dp 0x010, RAM[0x010]=0x41, ack_in high -> dce=1 da=0x010; next cycle operation=OP_INC, a_out=0x41, held while ack_in low 3 cycles.
REQ-041 OP_IN with crda low 4 cycles then cd=0x5A crda high -> ack 0 and operation 0 during wait; cack one cycle; a_out=0x5A.
REQ-042 OP_DEC, dp 0x020 RAM=0x07, wdce=1 wda=0x020 wdq=0x08 same cycle -> a_out=0x08.
REQ-043 Same with wda=0x021 -> a_out=0x07 (no forward).
REQ-044 OP_INC/OP_OUT/OP_INC consecutive, ack_in constant high -> three ops on consecutive cycles, correct a_out each, no bubbles.
